rx_share_arbiter: RTL and testbench

- Shares one `subcomponent` instance between two 10-bit receive streams, `data_rx_1` and `data_rx_2`.
- Arbitrates request beats round-robin, with bounded burst hold, onto the single `subcomponent` input.
- Records the source of every accepted beat in an in-order tag FIFO.
- Steers each `subcomponent` result back to the matching requester's transmit output.
- Sits between the top-level receive ports and the `subcomponent` instance.

---
 rtl/rx_share_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_rx_share_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_share_arbiter.sv
// -----------------------------------------------------------------------------
// rx_share_arbiter
//
// Shares a single downstream subcomponent between two receive streams.
// Request beats from requester 1 and requester 2 are arbitrated round-robin
// with a bounded burst length. The source of every accepted beat is recorded
// in an in-order tag FIFO, and each returning subcomponent result is steered
// back to the requester that issued the matching beat.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   enable                         gates new grants (an offer in flight completes)
//   rx_valid_1/data_rx_1/rx_ready_1  requester 1 beat handshake
//   rx_valid_2/data_rx_2/rx_ready_2  requester 2 beat handshake
//   sub_valid/sub_data_rx/sub_ready  beat offered to the subcomponent
//   sub_tx_valid/sub_data_tx         result returned by the subcomponent
//   tx_valid_1/data_tx_1             result routed to requester 1 (registered)
//   tx_valid_2/data_tx_2             result routed to requester 2 (registered)
//   busy                           tags outstanding or a beat on offer
//   err                            sticky: result arrived with no tag outstanding
//
// Arbiter states:
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no grant held; waits for enable and a valid requester
//   GNT1  | requester 1 owns the subcomponent input
//   GNT2  | requester 2 owns the subcomponent input
// -----------------------------------------------------------------------------
module rx_share_arbiter #(
  parameter int DW        = 10,
  parameter int TAG_DEPTH = 4,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          rx_valid_1,
  input  logic [DW-1:0] data_rx_1,
  output logic          rx_ready_1,
  input  logic          rx_valid_2,
  input  logic [DW-1:0] data_rx_2,
  output logic          rx_ready_2,
  output logic          sub_valid,
  output logic [DW-1:0] sub_data_rx,
  input  logic          sub_ready,
  input  logic          sub_tx_valid,
  input  logic [DW-1:0] sub_data_tx,
  output logic          tx_valid_1,
  output logic [DW-1:0] data_tx_1,
  output logic          tx_valid_2,
  output logic [DW-1:0] data_tx_2,
  output logic          busy,
  output logic          err
);

  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(TAG_DEPTH);
  localparam logic [BW-1:0] BURST_C = BW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_t;

  state_t          state;
  logic [BW-1:0]   burst_cnt;
  // Tag / last-served encoding: 0 = requester 1, 1 = requester 2.
  logic            last_served;

  logic [TAG_DEPTH-1:0] tag_mem;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        tag_count;

  logic          tag_not_full;
  logic          tag_not_empty;
  logic          accept;
  logic          pop;
  logic          gnt_is_2;
  logic          cur_valid;
  logic          other_valid;
  logic [BW-1:0] burst_inc;

  // ---------------------------------------------------------------------------
  // Tag FIFO status
  // ---------------------------------------------------------------------------
  assign tag_not_full  = (tag_count != DEPTH_C);
  assign tag_not_empty = (tag_count != '0);

  // ---------------------------------------------------------------------------
  // Request path: the granted requester is muxed straight through to the
  // subcomponent. Offers are withheld while the FIFO is full so that every
  // accepted beat is guaranteed a tag slot.
  // ---------------------------------------------------------------------------
  always_comb begin
    sub_valid   = 1'b0;
    sub_data_rx = '0;
    rx_ready_1  = 1'b0;
    rx_ready_2  = 1'b0;
    case (state)
      GNT1: begin
        sub_valid   = rx_valid_1 & tag_not_full;
        sub_data_rx = data_rx_1;
        rx_ready_1  = sub_ready & tag_not_full;
      end
      GNT2: begin
        sub_valid   = rx_valid_2 & tag_not_full;
        sub_data_rx = data_rx_2;
        rx_ready_2  = sub_ready & tag_not_full;
      end
      default: begin
        sub_valid   = 1'b0;
        sub_data_rx = '0;
      end
    endcase
  end

  assign accept      = sub_valid & sub_ready;
  assign gnt_is_2    = (state == GNT2);
  assign cur_valid   = gnt_is_2 ? rx_valid_2 : rx_valid_1;
  assign other_valid = gnt_is_2 ? rx_valid_1 : rx_valid_2;

  // Saturating so a long solo burst cannot wrap and hide the limit once the
  // other requester shows up.
  assign burst_inc = (burst_cnt >= BURST_C) ? BURST_C : burst_cnt + 1'b1;

  assign pop  = sub_tx_valid & tag_not_empty;
  assign busy = tag_not_empty | sub_valid;

  // ---------------------------------------------------------------------------
  // Arbiter FSM
  // The grant may only move on an accept or while nothing is offered, so an
  // offered beat is never withdrawn or swapped under the subcomponent.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (enable) begin
            if (rx_valid_1 && rx_valid_2) begin
              state <= last_served ? GNT1 : GNT2;
            end else if (rx_valid_1) begin
              state <= GNT1;
            end else if (rx_valid_2) begin
              state <= GNT2;
            end
          end
        end

        GNT1, GNT2: begin
          if (accept) begin
            last_served <= gnt_is_2;
            // cur_valid is necessarily high on an accept, so only the burst
            // limit can force a hand-over here.
            if (enable && other_valid && (burst_inc == BURST_C)) begin
              state     <= gnt_is_2 ? GNT1 : GNT2;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_inc;
            end
          end else if (!sub_valid && !cur_valid) begin
            if (!other_valid) begin
              state     <= IDLE;
              burst_cnt <= '0;
            end else if (enable) begin
              state     <= gnt_is_2 ? GNT1 : GNT2;
              burst_cnt <= '0;
            end
          end
        end

        default: begin
          state     <= IDLE;
          burst_cnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Tag FIFO (one bit per entry: which requester issued the beat)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_mem   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_count <= '0;
    end else begin
      if (accept) begin
        tag_mem[wr_ptr] <= gnt_is_2;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   tag_count <= tag_count + 1'b1;
        2'b01:   tag_count <= tag_count - 1'b1;
        default: tag_count <= tag_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing: one-cycle registered steer by the head tag. The data
  // registers only load for their own requester and otherwise hold.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_1 <= 1'b0;
      tx_valid_2 <= 1'b0;
      data_tx_1  <= '0;
      data_tx_2  <= '0;
      err        <= 1'b0;
    end else begin
      tx_valid_1 <= 1'b0;
      tx_valid_2 <= 1'b0;
      if (pop) begin
        if (tag_mem[rd_ptr]) begin
          tx_valid_2 <= 1'b1;
          data_tx_2  <= sub_data_tx;
        end else begin
          tx_valid_1 <= 1'b1;
          data_tx_1  <= sub_data_tx;
        end
      end
      if (sub_tx_valid && !tag_not_empty) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_share_arbiter.sv
module tb_rx_share_arbiter;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          rx_valid_1 = 1'b0;
  logic [DW-1:0] data_rx_1 = '0;
  logic          rx_ready_1;
  logic          rx_valid_2 = 1'b0;
  logic [DW-1:0] data_rx_2 = '0;
  logic          rx_ready_2;
  logic          sub_valid;
  logic [DW-1:0] sub_data_rx;
  logic          sub_ready = 1'b0;
  logic          sub_tx_valid = 1'b0;
  logic [DW-1:0] sub_data_tx = '0;
  logic          tx_valid_1;
  logic [DW-1:0] data_tx_1;
  logic          tx_valid_2;
  logic [DW-1:0] data_tx_2;
  logic          busy;
  logic          err;

  int checks = 0;
  int failures = 0;

  // Expected grant order with both requesters always valid, MAX_BURST = 4.
  int exp_src [10] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};

  rx_share_arbiter #(.DW(DW), .TAG_DEPTH(4), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .rx_valid_1   (rx_valid_1),
    .data_rx_1    (data_rx_1),
    .rx_ready_1   (rx_ready_1),
    .rx_valid_2   (rx_valid_2),
    .data_rx_2    (data_rx_2),
    .rx_ready_2   (rx_ready_2),
    .sub_valid    (sub_valid),
    .sub_data_rx  (sub_data_rx),
    .sub_ready    (sub_ready),
    .sub_tx_valid (sub_tx_valid),
    .sub_data_tx  (sub_data_tx),
    .tx_valid_1   (tx_valid_1),
    .data_tx_1    (data_tx_1),
    .tx_valid_2   (tx_valid_2),
    .data_tx_2    (data_tx_2),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge: the input drive window.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    enable       = 1'b0;
    rx_valid_1   = 1'b0;
    rx_valid_2   = 1'b0;
    data_rx_1    = '0;
    data_rx_2    = '0;
    sub_ready    = 1'b0;
    sub_tx_valid = 1'b0;
    sub_data_tx  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) cyc();
    settle();
    chk("rst_sub_valid", sub_valid, 0);
    chk("rst_rx_ready_1", rx_ready_1, 0);
    chk("rst_rx_ready_2", rx_ready_2, 0);
    chk("rst_tx_valid_1", tx_valid_1, 0);
    chk("rst_tx_valid_2", tx_valid_2, 0);
    chk("rst_data_tx_1", data_tx_1, 0);
    chk("rst_data_tx_2", data_tx_2, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    cyc();
    rst_n = 1'b1;

    // ---------------- single requester, 3 beats ----------------
    enable = 1'b1; sub_ready = 1'b1; rx_valid_1 = 1'b1; data_rx_1 = 10'h001;
    settle();
    chk("single_idle_no_offer", sub_valid, 0);
    cyc(); settle();
    chk("single_sub_valid", sub_valid, 1);
    chk("single_data_1", sub_data_rx, 10'h001);
    chk("single_ready_1", rx_ready_1, 1);
    chk("single_ready_2", rx_ready_2, 0);
    cyc(); data_rx_1 = 10'h002; settle();
    chk("single_data_2", sub_data_rx, 10'h002);
    cyc(); data_rx_1 = 10'h003; sub_tx_valid = 1'b1; sub_data_tx = 10'h001; settle();
    chk("single_busy", busy, 1);
    cyc(); rx_valid_1 = 1'b0; sub_data_tx = 10'h002; settle();
    chk("single_txv1_a", tx_valid_1, 1);
    chk("single_txd1_a", data_tx_1, 10'h001);
    chk("single_txv2_a", tx_valid_2, 0);
    cyc(); sub_data_tx = 10'h003; settle();
    chk("single_txv1_b", tx_valid_1, 1);
    chk("single_txd1_b", data_tx_1, 10'h002);
    cyc(); sub_tx_valid = 1'b0; settle();
    chk("single_txv1_c", tx_valid_1, 1);
    chk("single_txd1_c", data_tx_1, 10'h003);
    chk("single_txv2_c", tx_valid_2, 0);
    chk("single_busy_idle", busy, 0);
    cyc(); settle();
    chk("single_txv1_end", tx_valid_1, 0);
    chk("single_txd1_hold", data_tx_1, 10'h003);
    chk("single_err", err, 0);

    // ---------------- round robin with burst limit ----------------
    do_reset();
    enable = 1'b1; sub_ready = 1'b1;
    rx_valid_1 = 1'b1; rx_valid_2 = 1'b1;
    data_rx_1 = 10'h011; data_rx_2 = 10'h022;
    settle();
    chk("rr_idle_no_offer", sub_valid, 0);
    for (int w = 1; w <= 12; w++) begin
      cyc();
      rx_valid_1   = (w <= 10);
      rx_valid_2   = (w <= 10);
      sub_tx_valid = (w >= 2) && (w <= 11);
      sub_data_tx  = DW'(32'h100 + w);
      settle();
      if (w <= 10) begin
        chk("rr_sub_valid", sub_valid, 1);
        chk("rr_grant_data", sub_data_rx, (exp_src[w-1] == 1) ? 32'h011 : 32'h022);
        chk("rr_ready_1", rx_ready_1, (exp_src[w-1] == 1) ? 32'd1 : 32'd0);
        chk("rr_ready_2", rx_ready_2, (exp_src[w-1] == 2) ? 32'd1 : 32'd0);
      end
      if (w >= 3) begin
        chk("rr_tx_valid_1", tx_valid_1, (exp_src[w-3] == 1) ? 32'd1 : 32'd0);
        chk("rr_tx_valid_2", tx_valid_2, (exp_src[w-3] == 2) ? 32'd1 : 32'd0);
        chk("rr_data_tx", (exp_src[w-3] == 1) ? data_tx_1 : data_tx_2, 32'h100 + w - 1);
      end
    end

    // ---------------- backpressure on a requester-2 offer ----------------
    rx_valid_2 = 1'b1; data_rx_2 = 10'h2AA; rx_valid_1 = 1'b0; sub_ready = 1'b0;
    sub_tx_valid = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      cyc();
      if (b == 2) begin
        rx_valid_1 = 1'b1;
        data_rx_1  = 10'h155;
      end
      enable = (b < 3);
      settle();
      chk("bp_sub_valid", sub_valid, 1);
      chk("bp_data_stable", sub_data_rx, 10'h2AA);
      chk("bp_ready_1", rx_ready_1, 0);
      chk("bp_ready_2", rx_ready_2, 0);
    end
    cyc(); enable = 1'b1; sub_ready = 1'b1; settle();
    chk("bp_accept_ready_2", rx_ready_2, 1);
    chk("bp_accept_ready_1", rx_ready_1, 0);
    chk("bp_accept_data", sub_data_rx, 10'h2AA);
    cyc(); rx_valid_2 = 1'b0; settle();
    chk("bp_no_offer", sub_valid, 0);
    chk("bp_no_ready_1", rx_ready_1, 0);
    cyc(); settle();
    chk("bp_switch_valid", sub_valid, 1);
    chk("bp_switch_data", sub_data_rx, 10'h155);
    chk("bp_switch_ready_1", rx_ready_1, 1);
    chk("bp_switch_ready_2", rx_ready_2, 0);
    cyc(); rx_valid_1 = 1'b0; sub_tx_valid = 1'b1; sub_data_tx = 10'h0A1; settle();
    chk("bp_busy", busy, 1);
    cyc(); sub_data_tx = 10'h0A2; settle();
    chk("bp_route_txv2", tx_valid_2, 1);
    chk("bp_route_txd2", data_tx_2, 10'h0A1);
    chk("bp_route_txv1", tx_valid_1, 0);
    cyc(); sub_tx_valid = 1'b0; settle();
    chk("bp_route2_txv1", tx_valid_1, 1);
    chk("bp_route2_txd1", data_tx_1, 10'h0A2);
    chk("bp_route2_txv2", tx_valid_2, 0);
    chk("bp_route2_txd2_hold", data_tx_2, 10'h0A1);

    // ---------------- full tag FIFO ----------------
    cyc(); rx_valid_1 = 1'b1; data_rx_1 = 10'h0F0; sub_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc(); settle();
      chk("full_fill_offer", sub_valid, 1);
    end
    cyc(); settle();
    chk("full_sub_valid", sub_valid, 0);
    chk("full_ready_1", rx_ready_1, 0);
    chk("full_ready_2", rx_ready_2, 0);
    chk("full_busy", busy, 1);
    cyc(); sub_tx_valid = 1'b1; sub_data_tx = 10'h3C3; settle();
    chk("full_pop_cycle_no_offer", sub_valid, 0);
    cyc(); sub_tx_valid = 1'b0; settle();
    chk("full_reopen_valid", sub_valid, 1);
    chk("full_reopen_ready", rx_ready_1, 1);
    chk("full_pop_txv1", tx_valid_1, 1);
    chk("full_pop_txd1", data_tx_1, 10'h3C3);
    cyc(); settle();
    chk("full_again_valid", sub_valid, 0);
    chk("full_txv1_end", tx_valid_1, 0);

    // ---------------- result with empty FIFO ----------------
    do_reset();
    sub_tx_valid = 1'b1; sub_data_tx = 10'h155;
    settle();
    chk("err_pre", err, 0);
    cyc(); sub_tx_valid = 1'b0; settle();
    chk("err_set", err, 1);
    chk("err_txv1", tx_valid_1, 0);
    chk("err_txv2", tx_valid_2, 0);
    repeat (2) cyc();
    settle();
    chk("err_sticky", err, 1);

    // ---------------- reset mid-operation ----------------
    do_reset();
    enable = 1'b1; sub_ready = 1'b1; rx_valid_1 = 1'b1; data_rx_1 = 10'h011;
    cyc();
    cyc();
    cyc(); sub_ready = 1'b0; settle();
    chk("mid_offer_pending", sub_valid, 1);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sub_valid", sub_valid, 0);
    chk("mid_rst_sub_data", sub_data_rx, 0);
    chk("mid_rst_ready_1", rx_ready_1, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_txv1", tx_valid_1, 0);
    cyc();
    rst_n = 1'b1;
    rx_valid_2 = 1'b1; data_rx_1 = 10'h0B1; data_rx_2 = 10'h0B2;
    sub_tx_valid = 1'b1; sub_data_tx = 10'h3FF;
    settle();
    chk("mid_rel_idle", sub_valid, 0);
    cyc(); sub_tx_valid = 1'b0; settle();
    chk("mid_stale_err", err, 1);
    chk("mid_stale_txv1", tx_valid_1, 0);
    chk("mid_stale_txv2", tx_valid_2, 0);
    chk("mid_first_grant_valid", sub_valid, 1);
    chk("mid_first_grant_data", sub_data_rx, 10'h0B1);
    chk("mid_first_grant_ready_2", rx_ready_2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
